alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
Shares one ALU datapath (opcode decoder plus arithmetic/logic/shift units) between NUM_REQ requesters. Each cycle it selects one valid request by round-robin, registers opcode and operands into the ALU, and tracks the requester ID through the fixed ALU latency. Results are captured into a response FIFO that drives a single valid/ready response port. A credit scheme guarantees that every issued operation has a FIFO slot when its result returns.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, operand/result width
ALU_LATENCY, 1, cycles from alu_valid to alu_result valid (0..4; 0 = combinational ALU)
FIFO_DEPTH, 4, response FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant (handshake = valid & ready)
req_opcode  input  NUM_REQ*4  packed 4-bit opcodes, requester i at [4i+3:4i]
req_a  input  NUM_REQ*DATA_WIDTH  packed operand A
req_b  input  NUM_REQ*DATA_WIDTH  packed operand B
alu_valid  output  1  issue strobe to ALU
alu_opcode  output  4  opcode to ALU control decoder
alu_a  output  DATA_WIDTH  operand A to ALU
alu_b  output  DATA_WIDTH  operand B to ALU
alu_result  input  DATA_WIDTH  ALU result
alu_flags  input  4  ALU flags {Z,N,C,V}
rsp_valid  output  1  response valid
rsp_ready  input  1  response accepted
rsp_id  output  max(1,$clog2(NUM_REQ))  originating requester
rsp_result  output  DATA_WIDTH  result
rsp_flags  output  4  flags
busy  output  1  any op in flight or FIFO non-empty

Behaviour:
- Reset: all outputs 0. RR pointer = 0 (requester 0 highest priority). FIFO empty. In-flight count 0. Pipeline valids cleared. Applies asynchronously at any time, including mid-operation; all in-flight ops and FIFO contents are discarded.
- Credit: occ = inflight + fifo_count. can_issue = (occ < FIFO_DEPTH). A pop in the current cycle does not free a credit until the next cycle.
- Arbitration (combinational): if can_issue, req_ready is one-hot on the first requester with req_valid, searching from the RR pointer upward with wrap. Otherwise req_ready = 0. req_ready never depends on rsp_ready in the same cycle.
- RR pointer: on a handshake with requester g, the pointer becomes (g+1) mod NUM_REQ. It is unchanged when there is no grant.
- Issue: on a handshake in cycle T, alu_valid/opcode/a/b are registered and valid in cycle T+1 for exactly one cycle. When alu_valid = 0, the opcode and operand outputs hold their last values.
- Tag pipeline: a shift register of {valid, id}, ALU_LATENCY+1 stages from the issue register. The ALU result is sampled in cycle T+1+ALU_LATENCY when the tag valid is set, then pushed as {id, result, flags}.
- FIFO: registered output. rsp_valid is asserted at T+2+ALU_LATENCY at the earliest. A pop occurs on rsp_valid & rsp_ready. Push and pop in the same cycle are legal at any occupancy, including full. Overflow is impossible by credit; flag an assertion error under SIMULATION if it occurs.
- inflight: +1 on handshake, -1 on push. Both in the same cycle leave it unchanged.
- The rsp_* fields hold stable while rsp_valid & !rsp_ready.
- All 16 opcodes pass through unmodified; the arbiter does not decode them.
- Sustained throughput: one op per cycle while rsp_ready = 1.
- busy = (inflight != 0) | (fifo_count != 0).

Test Plan:
- Reset: hold rst_n = 0 with all req_valid = 1 -> req_ready = 0, alu_valid = 0, rsp_valid = 0, busy = 0. Release -> requester 0 is granted first.
- Single op: requester 2 issues opcode 0000 with a = 5, b = 3, ALU_LATENCY = 1, handshake at cycle T -> alu_valid at T+1 with a = 5, b = 3; rsp_valid at T+3 with rsp_id = 2, rsp_result = 8, rsp_flags Z = 0.
- Contention: all 4 requesters held valid, rsp_ready = 1 -> grants in order 0,1,2,3,0,... one per cycle; responses return in issue order with matching IDs.
- Backpressure: rsp_ready = 0, requester 1 streaming -> exactly FIFO_DEPTH = 4 handshakes, then req_ready = 0 and busy = 1. Raise rsp_ready -> 4 responses drain, one per cycle, and issue resumes the cycle after the first pop.
- Full simultaneous push/pop: FIFO at 3 entries with 1 op in flight, rsp_ready = 1 -> push and pop occur in the same cycle, count stays 3, and no data is lost or duplicated.
- Mid-operation reset: assert rst_n = 0 with 2 ops in flight and 2 FIFO entries -> outputs immediately 0. After release, a new op returns only its own response and no stale IDs appear.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of NUM_REQ requesters onto one shared ALU.
// The block registers the winning opcode and operands towards the ALU. It follows
// each operation's requester ID through the ALU latency, then queues
// {id, result, flags} in a response FIFO. Credits (in flight + queued) keep the
// number of outstanding operations at or below FIFO_DEPTH, so the FIFO can never
// overflow.
//
// Handshake semantics: a transfer happens on a port in any cycle where valid and
// ready are both high at the rising clock edge. req_ready is combinational from
// req_valid, the round-robin pointer and the registered credit state only. It
// never depends on rsp_ready. rsp_* stays stable while rsp_valid is high and
// rsp_ready is low.
module alu_issue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*4-1:0]          req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          alu_valid,
  output logic [3:0]                    alu_opcode,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic [3:0]                    alu_flags,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic [3:0]                    rsp_flags,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IDW + DATA_WIDTH + 4;

  // Arbitration / credit state
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        grant_id;
  logic [IDW-1:0]        grant_off;
  logic [IDW:0]          grant_sum;
  logic [NUM_REQ-1:0]    rot_valid;
  logic                  grant_found;
  logic                  can_issue;
  logic                  hs;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ;

  // Selected request fields
  logic [3:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  // Tag pipeline: stage 0 is the issue register, stage ALU_LATENCY meets the result
  logic [ALU_LATENCY:0]  tag_v;
  logic [IDW-1:0]        tag_id [ALU_LATENCY+1];

  // Response FIFO
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         push_data;

  // Credit: a pop frees its slot only once fifo_count has been updated
  assign occ       = {1'b0, inflight} + {1'b0, fifo_count};
  assign can_issue = rst_n && (occ < (CW+1)'(FIFO_DEPTH));

  // Round-robin search: rotate valids so the pointer is at bit 0, take first set bit
  always_comb begin
    rot_valid   = '0;
    grant_found = 1'b0;
    grant_off   = '0;
    if (can_issue) begin
      rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = IDW'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    if (grant_sum >= (IDW+1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (IDW+1)'(NUM_REQ);
    end
    grant_id = grant_sum[IDW-1:0];
  end

  assign req_ready = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
  assign hs        = grant_found;

  // Operand mux for the granted requester
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_op = req_opcode[k*4 +: 4];
        sel_a  = req_a[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = req_b[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pointer: move just past the winner, hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Issue register: operands only load on a grant so they hold between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (hs) begin
      alu_opcode <= sel_op;
      alu_a      <= sel_a;
      alu_b      <= sel_b;
    end
  end

  // Tag shift register carrying {valid, id} alongside the ALU pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k <= ALU_LATENCY; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= hs;
      tag_id[0] <= grant_id;
      for (int k = 1; k <= ALU_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign alu_valid = tag_v[0];
  assign push      = tag_v[ALU_LATENCY];
  assign push_data = {tag_id[ALU_LATENCY], alu_result, alu_flags};

  // Ops issued but not yet pushed into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({hs, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Response FIFO storage and pointers; storage is cleared so outputs read 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign {rsp_id, rsp_result, rsp_flags} = mem[rd_ptr];
  assign busy = (inflight != '0) || (fifo_count != '0);

`ifdef SIMULATION
  // Credit accounting must make a push into a full FIFO without a pop impossible
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (fifo_count == CW'(FIFO_DEPTH))))
        else $error("alu_issue_arbiter: response FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed phases plus random traffic. A behavioural ALU
// drives alu_result. A reference model of the arbiter rules predicts grants, issue
// strobes and response timing. A monitor pops the expected-response queue.
module tb_alu_issue_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int L   = 1;
  localparam int D   = 4;
  localparam int IDW = 2;
  localparam int EW  = IDW + DW + 4;

  logic               clk;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*4-1:0]    req_opcode;
  logic [NR*DW-1:0]   req_a;
  logic [NR*DW-1:0]   req_b;
  logic               alu_valid;
  logic [3:0]         alu_opcode;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic [DW-1:0]      alu_result;
  logic [3:0]         alu_flags;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_result;
  logic [3:0]         rsp_flags;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard queues
  logic [EW-1:0] exp_q[$];
  int            rc_q[$];
  int            out_cyc[$];

  // Model state
  int            ptr_m;
  int            g_m;
  int            idx_m;
  logic [NR-1:0] rv_m;
  logic [NR-1:0] exp_ready_m;
  logic          prev_hs;
  logic [3:0]    prev_op;
  logic [DW-1:0] prev_a;
  logic [DW-1:0] prev_b;
  logic [3:0]    op_m;
  logic [DW-1:0] a_m;
  logic [DW-1:0] b_m;
  logic [DW+3:0] res_m;
  logic          exp_v;

  alu_issue_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ALU_LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU, returns {flags {Z,N,C,V}, result}
  function automatic logic [DW+3:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW:0]   w;
    logic [DW-1:0] r;
    logic          c;
    logic          v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[DW-1:0]; c = w[DW];
                   v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[DW-1:0]; c = w[DW];
                   v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = a * b;
      4'd9:  r = a;
      4'd10: r = b;
      4'd11: r = ~a;
      4'd12: r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd13: r = {{(DW-1){1'b0}}, (a < b)};
      4'd14: r = ~(a & b);
      default: r = ~(a | b);
    endcase
    return {(r == '0), r[DW-1], c, v, r};
  endfunction

  initial begin
    alu_result = '0;
    alu_flags  = '0;
  end
  always @(posedge clk) begin
    if (alu_valid) {alu_flags, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: grant rule, credit limit, issue strobe, expected responses
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_alu_valid", 64'(alu_valid), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      ptr_m = 0;
      prev_hs = 1'b0;
      out_cyc.delete();
      exp_q.delete();
      rc_q.delete();
    end else begin
      g_m  = -1;
      rv_m = req_valid;
      if (out_cyc.size() < D) begin
        for (int k = 0; k < NR; k++) begin
          idx_m = (ptr_m + k) % NR;
          if (g_m < 0 && rv_m[idx_m[IDW-1:0]]) g_m = idx_m;
        end
      end
      exp_ready_m = (g_m >= 0) ? (NR'(1) << g_m) : '0;
      check("grant", 64'(req_ready), 64'(exp_ready_m));
      check("busy", 64'(busy), 64'(out_cyc.size() != 0));
      check("alu_valid", 64'(alu_valid), 64'(prev_hs));
      if (prev_hs) begin
        check("alu_opcode", 64'(alu_opcode), 64'(prev_op));
        check("alu_a", 64'(alu_a), 64'(prev_a));
        check("alu_b", 64'(alu_b), 64'(prev_b));
      end
      if (out_cyc.size() > 0 && out_cyc[0] <= cyc && rsp_ready) void'(out_cyc.pop_front());
      if (g_m >= 0) begin
        op_m  = 4'(req_opcode >> (g_m * 4));
        a_m   = DW'(req_a >> (g_m * DW));
        b_m   = DW'(req_b >> (g_m * DW));
        res_m = alu_fn(op_m, a_m, b_m);
        exp_q.push_back({IDW'(g_m), res_m[DW-1:0], res_m[DW+3:DW]});
        rc_q.push_back(cyc + 2 + L);
        out_cyc.push_back(cyc + 2 + L);
        prev_hs = 1'b1;
        prev_op = op_m;
        prev_a  = a_m;
        prev_b  = b_m;
        ptr_m   = (g_m + 1) % NR;
      end else begin
        prev_hs = 1'b0;
      end
    end
  end

  // Monitor: response presence, contents while presented, pop on acceptance
  always @(negedge clk) begin
    if (rst_n) begin
      exp_v = (rc_q.size() > 0) && (rc_q[0] <= cyc);
      check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (rsp_valid && exp_v) begin
        check("rsp_data", 64'({rsp_id, rsp_result, rsp_flags}), 64'(exp_q[0]));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          void'(rc_q.pop_front());
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic [NR-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    for (int k = 0; k < NR; k++) begin
      req_opcode[k*4 +: 4] = 4'($urandom_range(0, 15));
      req_a[k*DW +: DW]    = $urandom();
      req_b[k*DW +: DW]    = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 40));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(input int r, input logic [3:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
    req_valid = NR'(1) << r;
    rsp_ready = 1'b1;
    req_opcode[r*4 +: 4] = op;
    req_a[r*DW +: DW]    = a;
    req_b[r*DW +: DW]    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero();
    check("async_rst_req_ready", 64'(req_ready), 64'(0));
    check("async_rst_alu_valid", 64'(alu_valid), 64'(0));
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
  endtask

  // Stimulus sequence
  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    rsp_ready  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First grant after reset goes to requester 0
    drive('1, 1'b1);
    repeat (6) drive('0, 1'b1);

    // Single op: requester 2, add 5 + 3
    drive_one(2, 4'd0, 32'd5, 32'd3);
    repeat (6) drive('0, 1'b1);

    // Contention: all requesters valid
    repeat (12) drive('1, 1'b1);
    repeat (6) drive('0, 1'b1);

    // Backpressure: credits run out after FIFO_DEPTH issues, then drain
    repeat (8) drive(4'b0010, 1'b0);
    repeat (10) drive(4'b0010, 1'b1);
    repeat (6) drive('0, 1'b1);

    // Three queued + one in flight, then simultaneous push and pop
    repeat (5) drive(4'b0100, 1'b0);
    repeat (8) drive(4'b0100, 1'b1);
    repeat (6) drive('0, 1'b1);

    // Mid-operation reset with two in flight and two queued
    repeat (4) drive(4'b1000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero();
    repeat (2) drive('1, 1'b0);
    rst_n = 1'b1;
    drive_one(1, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    repeat (6) drive('0, 1'b1);

    // Random traffic
    repeat (400) drive(NR'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
    repeat (12) drive('0, 1'b1);

    check("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
